// File: rtl/cache_mem_pkg.sv
// Shared state, requester and burst-geometry definitions for the cache/memory arbiter.
package cache_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_BURST,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

    localparam int BURST_LEN = 4;
    localparam int CNT_W     = $clog2(BURST_LEN);

endpackage

// File: rtl/burst_deserializer.sv
// Assembles BURST_LEN memory beats into one cache line; beat 0 lands in the low bits.
module burst_deserializer
    import cache_mem_pkg::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   beat_vld,
    input  logic [BURST_WIDTH-1:0] beat_data,
    output logic                   line_done,
    output logic [LINE_WIDTH-1:0]  line
);

    localparam int PART_W = LINE_WIDTH - BURST_WIDTH;

    logic [CNT_W-1:0]  count;
    logic [PART_W-1:0] partial;

    assign line_done = beat_vld && (count == CNT_W'(BURST_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            line  <= '0;
        end else if (beat_vld) begin
            count <= count + 1'b1;
            if (line_done) begin
                line <= {beat_data, partial};
            end
        end
    end

    // Partial slots need no reset: count restarts at 0, so each slot is rewritten before use.
    always_ff @(posedge clk) begin
        if (beat_vld && !line_done) begin
            partial[int'(count)*BURST_WIDTH +: BURST_WIDTH] <= beat_data;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one burst-memory port between I-cache and D-cache line requests.
module cache_mem_arbiter
    import cache_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  i_dfp_addr,
    input  logic                   i_dfp_read,
    output logic [LINE_WIDTH-1:0]  i_dfp_rdata,
    output logic                   i_dfp_resp,
    input  logic [ADDR_WIDTH-1:0]  d_dfp_addr,
    input  logic                   d_dfp_read,
    input  logic                   d_dfp_write,
    input  logic [LINE_WIDTH-1:0]  d_dfp_wdata,
    output logic [LINE_WIDTH-1:0]  d_dfp_rdata,
    output logic                   d_dfp_resp,
    output logic [ADDR_WIDTH-1:0]  bmem_addr,
    output logic                   bmem_read,
    output logic                   bmem_write,
    output logic [BURST_WIDTH-1:0] bmem_wdata,
    input  logic                   bmem_ready,
    input  logic [ADDR_WIDTH-1:0]  bmem_raddr,
    input  logic [BURST_WIDTH-1:0] bmem_rdata,
    input  logic                   bmem_rvalid
);

    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);

    arb_state_t             state_q, state_d;
    req_id_t                gnt_q, last_grant_q, take_id;
    logic                   take, take_wr;
    logic [ADDR_WIDTH-1:0]  sel_addr, addr_q;
    logic [LINE_WIDTH-1:0]  wdata_q;
    logic [CNT_W-1:0]       wr_cnt_q;
    logic                   i_req, d_req, beat_vld, line_done;
    logic [LINE_WIDTH-1:0]  line;

    assign i_req    = i_dfp_read;
    assign d_req    = d_dfp_read || d_dfp_write;
    assign beat_vld = (state_q == RD_WAIT) && bmem_rvalid && (bmem_raddr == addr_q);

    burst_deserializer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BURST_WIDTH(BURST_WIDTH)
    ) u_deser (
        .clk      (clk),
        .rst      (rst),
        .beat_vld (beat_vld),
        .beat_data(bmem_rdata),
        .line_done(line_done),
        .line     (line)
    );

    // Both caches see the last assembled line; only the resp pulse says whose it is.
    assign i_dfp_rdata = line;
    assign d_dfp_rdata = line;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= REQ_I;
            last_grant_q <= REQ_I;
            addr_q       <= '0;
            wr_cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                gnt_q        <= take_id;
                last_grant_q <= take_id;
                addr_q       <= sel_addr & LINE_MASK;
            end
            if (bmem_write) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take && take_wr) begin
            wdata_q <= d_dfp_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        take       = 1'b0;
        take_id    = REQ_I;
        take_wr    = 1'b0;
        sel_addr   = i_dfp_addr;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        i_dfp_resp = 1'b0;
        d_dfp_resp = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (i_req && d_req) begin
                    take_id = (last_grant_q == REQ_I) ? REQ_D : REQ_I;
                end else if (d_req) begin
                    take_id = REQ_D;
                end
                take     = i_req || d_req;
                take_wr  = (take_id == REQ_D) && d_dfp_write;
                sel_addr = (take_id == REQ_D) ? d_dfp_addr : i_dfp_addr;
                if (take) begin
                    state_d = take_wr ? WR_BURST : RD_REQ;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    bmem_read = 1'b1;
                    bmem_addr = addr_q;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (line_done) begin
                    state_d = RESP;
                end
            end
            WR_BURST: begin
                // Only beat 0 waits for ready; the rest stream out back to back.
                if (wr_cnt_q != '0 || bmem_ready) begin
                    bmem_write = 1'b1;
                    bmem_addr  = addr_q;
                    bmem_wdata = wdata_q[int'(wr_cnt_q)*BURST_WIDTH +: BURST_WIDTH];
                    if (wr_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                i_dfp_resp = (gnt_q == REQ_I);
                d_dfp_resp = (gnt_q == REQ_D);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A granted requester must keep its request up until its resp pulse.
    a_i_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q != IDLE && gnt_q == REQ_I) |-> i_dfp_read);
    a_d_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q != IDLE && gnt_q == REQ_D) |-> (d_dfp_read || d_dfp_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter with a behavioural burst-memory model.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

    logic         clk, rst;
    logic [31:0]  i_dfp_addr, d_dfp_addr, bmem_addr, bmem_raddr;
    logic         i_dfp_read, i_dfp_resp, d_dfp_read, d_dfp_write, d_dfp_resp;
    logic [255:0] i_dfp_rdata, d_dfp_rdata, d_dfp_wdata;
    logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0]  bmem_wdata, bmem_rdata;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } exp_t;

    exp_t        i_exp[$];
    exp_t        d_exp[$];
    int          resp_order[$];
    logic [31:0] pend[$];
    int          tests, fails, i_resp_cnt, cyc, beats_sent;
    int          cfg_lat, cfg_stray;
    bit          cfg_rand_ready, force_low;

    cache_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_dfp_addr (i_dfp_addr),
        .i_dfp_read (i_dfp_read),
        .i_dfp_rdata(i_dfp_rdata),
        .i_dfp_resp (i_dfp_resp),
        .d_dfp_addr (d_dfp_addr),
        .d_dfp_read (d_dfp_read),
        .d_dfp_write(d_dfp_write),
        .d_dfp_wdata(d_dfp_wdata),
        .d_dfp_rdata(d_dfp_rdata),
        .d_dfp_resp (d_dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_beat(input logic [31:0] a, input int k);
        return {a ^ (32'h9E37_79B9 * 32'(k + 1)), ~a + 32'(k)};
    endfunction

    function automatic logic [255:0] exp_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = mem_beat(a, k);
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic wait_resp(input bit is_d, output int n);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (is_d ? d_dfp_resp : i_dfp_resp) return;
        end
        check(is_d ? "d_resp_timeout" : "i_resp_timeout", 1, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cache side: issue n line requests one after another, each held until its resp.
    task automatic side(input bit is_d, input int n, input bit rnd, input logic [31:0] base);
        exp_t        e;
        logic [31:0] a;
        bit          wr;
        int          lat;
        for (int k = 0; k < n; k++) begin
            if (rnd) repeat ($urandom_range(0, 3)) tick();
            a      = rnd ? (32'h6000_0000 | ($urandom & 32'h0FFF_FFFF)) : base + 32'(k) * 32'h40;
            e.addr = a & 32'hFFFF_FFE0;
            wr     = is_d && rnd && ($urandom_range(0, 1) == 1);
            e.wr   = wr;
            e.line = wr ? rand_line() : exp_line(e.addr);
            if (is_d) begin
                d_dfp_addr  = a;
                d_dfp_wdata = e.line;
                d_dfp_write = wr;
                d_dfp_read  = !wr || ($urandom_range(0, 2) == 0);
                d_exp.push_back(e);
            end else begin
                i_dfp_addr = a;
                i_dfp_read = 1'b1;
                i_exp.push_back(e);
            end
            wait_resp(is_d, lat);
            tick();
            if (is_d) begin
                d_dfp_read  = 1'b0;
                d_dfp_write = 1'b0;
            end else begin
                i_dfp_read = 1'b0;
            end
        end
    endtask

    // Burst memory: queues read requests, returns 4 tagged beats after a latency, may inject strays.
    initial begin
        logic [31:0] cur;
        bit          act, stray_done;
        int          lat, k;
        bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
        act = 1'b0; beats_sent = 0; lat = 0; k = 0; stray_done = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
                act = 1'b0;
            end else if (bmem_read) begin
                pend.push_back(bmem_addr);
            end
            tick();
            bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
            bmem_ready  = !force_low && (!cfg_rand_ready || $urandom_range(0, 2) != 0);
            if (!act && pend.size() > 0) begin
                cur = pend.pop_front();
                act = 1'b1; k = 0; beats_sent = 0; stray_done = 1'b0;
                lat = (cfg_lat >= 0) ? cfg_lat : $urandom_range(0, 4);
            end
            if (act) begin
                if (lat > 0) begin
                    lat--;
                end else if ((cfg_stray == 1 && k == 2 && !stray_done) ||
                             (cfg_stray == 2 && $urandom_range(0, 3) == 0)) begin
                    bmem_rvalid = 1'b1; bmem_raddr = 32'h3000_0000; bmem_rdata = {$urandom, $urandom};
                    stray_done = 1'b1;
                end else begin
                    bmem_rvalid = 1'b1; bmem_raddr = cur; bmem_rdata = mem_beat(cur, k);
                    k++;
                    beats_sent = k;
                    if (k == 4) act = 1'b0;
                end
            end else if (cfg_stray == 2 && $urandom_range(0, 7) == 0) begin
                bmem_rvalid = 1'b1; bmem_raddr = 32'h3000_0000; bmem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Monitor: gathers memory-side activity and checks each resp against the scoreboard.
    initial begin
        exp_t         e;
        logic [255:0] wl;
        logic [31:0]  wa0, rda;
        int           wn, wfirst, wlast, rdp;
        bit           wbad;
        wn = 0; rdp = 0; wbad = 1'b0; wfirst = 0; wlast = 0; wa0 = '0; rda = '0; wl = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                wn = 0; rdp = 0; wbad = 1'b0;
                continue;
            end
            if (bmem_read) begin
                rdp++;
                rda = bmem_addr;
            end
            if (bmem_write) begin
                if (wn < 4) wl[64*wn +: 64] = bmem_wdata;
                if (wn == 0) begin
                    wa0 = bmem_addr;
                    wfirst = cyc;
                end else if (bmem_addr != wa0) begin
                    wbad = 1'b1;
                end
                wlast = cyc;
                wn++;
            end
            if (i_dfp_resp && d_dfp_resp) check("dual_resp", 1, 0);
            if (i_dfp_resp) begin
                i_resp_cnt++;
                resp_order.push_back(0);
                if (i_exp.size() == 0) begin
                    check("i_unexpected_resp", 1, 0);
                end else begin
                    e = i_exp.pop_front();
                    check("i_rdata", i_dfp_rdata, e.line);
                    check("i_rd_pulses", rdp, 1);
                    check("i_rd_addr", rda, e.addr);
                end
                rdp = 0;
            end
            if (d_dfp_resp) begin
                resp_order.push_back(1);
                if (d_exp.size() == 0) begin
                    check("d_unexpected_resp", 1, 0);
                end else begin
                    e = d_exp.pop_front();
                    if (e.wr) begin
                        check("d_wr_beats", wn, 4);
                        check("d_wdata", wl, e.line);
                        check("d_wr_addr", wa0, e.addr);
                        check("d_wr_addr_hold", wbad, 0);
                        check("d_wr_consecutive", wlast - wfirst, 3);
                        check("d_wr_no_read", rdp, 0);
                    end else begin
                        check("d_rdata", d_dfp_rdata, e.line);
                        check("d_rd_pulses", rdp, 1);
                        check("d_rd_addr", rda, e.addr);
                        check("d_rd_no_write", wn, 0);
                    end
                end
                rdp = 0; wn = 0; wbad = 1'b0;
            end
        end
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   lat, n0, guard;
        tests = 0; fails = 0; i_resp_cnt = 0; cyc = 0;
        rst = 1'b1; cfg_lat = 2; cfg_stray = 0; cfg_rand_ready = 1'b0; force_low = 1'b0;
        i_dfp_addr = '0; i_dfp_read = 1'b0; d_dfp_addr = '0; d_dfp_read = 1'b0;
        d_dfp_write = 1'b0; d_dfp_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_bmem_read", bmem_read, 0);
        check("rst_bmem_write", bmem_write, 0);
        check("rst_bmem_addr", bmem_addr, 0);
        check("rst_bmem_wdata", bmem_wdata, 0);
        check("rst_i_resp", i_dfp_resp, 0);
        check("rst_d_resp", d_dfp_resp, 0);
        check("rst_i_rdata", i_dfp_rdata, 0);
        check("rst_d_rdata", d_dfp_rdata, 0);
        tick();

        // Single I read from a mid-line address.
        side(0, 1, 0, 32'h1000_0004);

        // D write-back with memory always ready: resp on the sixth cycle.
        e.wr = 1'b1; e.addr = 32'h2000_0020; e.line = rand_line();
        d_dfp_addr = 32'h2000_0020; d_dfp_wdata = e.line; d_dfp_write = 1'b1;
        d_exp.push_back(e);
        wait_resp(1, lat);
        check("wr_latency", lat, 6);
        tick();
        d_dfp_write = 1'b0;

        // Both sides requesting from reset: ties alternate starting with D.
        rst = 1'b1;
        resp_order.delete();
        fork
            side(0, 4, 0, 32'h5000_0000);
            side(1, 4, 0, 32'h4000_0000);
            begin
                repeat (3) tick();
                rst = 1'b0;
            end
        join
        check("order_len", resp_order.size(), 8);
        for (int k = 0; k < 8 && k < resp_order.size(); k++)
            check($sformatf("order_%0d", k), resp_order[k], (k % 2 == 0) ? 1 : 0);

        // Memory not ready: the read request must wait and then pulse once.
        force_low = 1'b1;
        tick();
        fork
            side(0, 1, 0, 32'h1234_5660);
            begin
                repeat (6) begin
                    @(negedge clk);
                    check("rd_wait_ready", bmem_read, 0);
                end
                tick();
                force_low = 1'b0;
            end
        join

        // Stray beat from another address lands between beats 1 and 2.
        cfg_stray = 1;
        side(0, 1, 0, 32'h0ABC_DE80);
        side(1, 1, 0, 32'h0ABC_DF00);
        cfg_stray = 0;

        // Reset while beat 2 is on the bus, then the same line again.
        cfg_lat = 1;
        e.wr = 1'b0; e.addr = 32'h7000_0040; e.line = exp_line(32'h7000_0040);
        i_dfp_addr = 32'h7000_0040; i_dfp_read = 1'b1;
        i_exp.push_back(e);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (beats_sent != 2 && guard < 50);
        check("rst_mid_beats_seen", beats_sent, 2);
        tick();
        rst = 1'b1; i_dfp_read = 1'b0;
        i_exp.delete();
        n0 = i_resp_cnt;
        tick();
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_mid_no_resp", i_resp_cnt, n0);
        tick();
        side(0, 1, 0, 32'h7000_0040);

        // Random contention with random latency, readiness and stray beats.
        cfg_lat = -1; cfg_stray = 2; cfg_rand_ready = 1'b1;
        fork
            side(0, 25, 1, 32'h0);
            side(1, 25, 1, 32'h0);
        join
        repeat (4) tick();
        check("i_exp_drained", i_exp.size(), 0);
        check("d_exp_drained", d_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
